// File: rtl/vx_commit_rr_arb_if.sv
// Commit-stream bundle between NUM_REQS execute-unit commit outputs and the shared writeback port.
// slave = arbiter view, master = requester/writeback (environment) view.
interface vx_commit_rr_arb_if #(
  parameter int NUM_REQS   = 4,
  parameter int DATA_WIDTH = 64,
  parameter int PERF_W     = 32
) ();
  localparam int SEL_W = $clog2(NUM_REQS);

  logic [NUM_REQS-1:0]            req_valid;
  logic [NUM_REQS*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQS-1:0]            req_eop;
  logic [NUM_REQS-1:0]            req_ready;
  logic                           out_valid;
  logic [DATA_WIDTH-1:0]          out_data;
  logic                           out_eop;
  logic [SEL_W-1:0]               out_sel;
  logic                           out_ready;
  logic [PERF_W-1:0]              perf_stalls;

  modport slave (
    input  req_valid, req_data, req_eop, out_ready,
    output req_ready, out_valid, out_data, out_eop, out_sel, perf_stalls
  );

  modport master (
    output req_valid, req_data, req_eop, out_ready,
    input  req_ready, out_valid, out_data, out_eop, out_sel, perf_stalls
  );
endinterface

// File: rtl/vx_commit_rr_arb.sv
// Packet-aware round-robin arbiter onto one registered commit port: 1-cycle latency, 1 beat/cycle;
// req_ready is withheld whenever the output register is full and not draining.
module vx_commit_rr_arb #(
  parameter int NUM_REQS   = 4,
  parameter int DATA_WIDTH = 64,
  parameter int PERF_W     = 32
) (
  input logic               clk_i,
  input logic               rst_i,
  vx_commit_rr_arb_if.slave bus
);
  localparam int SEL_W = $clog2(NUM_REQS);

  typedef enum logic {ST_IDLE, ST_LOCKED} state_e;

  state_e                state_q, state_d;
  logic [SEL_W-1:0]      lock_idx_q, lock_idx_d;
  logic [SEL_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [SEL_W-1:0]      out_sel_q, out_sel_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_eop_q, out_eop_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [PERF_W-1:0]     perf_q, perf_d;

  logic [NUM_REQS-1:0]   grant;
  logic [SEL_W-1:0]      gnt_idx;
  logic                  gnt_vld;
  logic                  can_load;
  logic                  accept;
  logic                  stall;
  logic [DATA_WIDTH-1:0] gnt_data;
  logic                  gnt_eop;
  int                    idx;

  // Held low in reset so no requester sees a handshake while the stage is being cleared.
  assign can_load = !rst_i && (!out_valid_q || bus.out_ready);

  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    idx     = 0;
    if (state_q == ST_LOCKED) begin
      gnt_idx = lock_idx_q;
      gnt_vld = bus.req_valid[lock_idx_q];
    end else begin
      // Walk from farthest to nearest so the nearest valid requester after rr_ptr wins.
      for (int k = NUM_REQS; k >= 1; k--) begin
        idx = (int'(rr_ptr_q) + k) % NUM_REQS;
        if (bus.req_valid[idx]) begin
          gnt_idx = SEL_W'(idx);
          gnt_vld = 1'b1;
        end
      end
    end
    grant[gnt_idx] = gnt_vld;
  end

  assign gnt_data      = bus.req_data[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
  assign gnt_eop       = bus.req_eop[gnt_idx];
  assign accept        = gnt_vld && can_load;
  assign stall         = (|bus.req_valid) && !accept;
  assign bus.req_ready = grant & {NUM_REQS{can_load}};

  always_comb begin
    state_d     = state_q;
    lock_idx_d  = lock_idx_q;
    rr_ptr_d    = rr_ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_eop_d   = out_eop_q;
    out_sel_d   = out_sel_q;
    perf_d      = perf_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = gnt_data;
      out_eop_d   = gnt_eop;
      out_sel_d   = gnt_idx;
      if (gnt_eop) begin
        state_d  = ST_IDLE;
        rr_ptr_d = gnt_idx;
      end else begin
        state_d    = ST_LOCKED;
        lock_idx_d = gnt_idx;
      end
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
    if (stall && (perf_q != {PERF_W{1'b1}})) begin
      perf_d = perf_q + PERF_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      lock_idx_q  <= '0;
      rr_ptr_q    <= SEL_W'(NUM_REQS - 1);
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_eop_q   <= 1'b0;
      out_sel_q   <= '0;
      perf_q      <= '0;
    end else begin
      state_q     <= state_d;
      lock_idx_q  <= lock_idx_d;
      rr_ptr_q    <= rr_ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_eop_q   <= out_eop_d;
      out_sel_q   <= out_sel_d;
      perf_q      <= perf_d;
    end
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.out_data    = out_data_q;
  assign bus.out_eop     = out_eop_q;
  assign bus.out_sel     = out_sel_q;
  assign bus.perf_stalls = perf_q;
endmodule

// File: tb/tb_vx_commit_rr_arb.sv
// Scenario bench for vx_commit_rr_arb (4 requesters, 8-bit payload): per-feature tasks plus an
// output scoreboard fed with the expected beat order as stimulus is driven.
module tb_vx_commit_rr_arb;
  typedef struct packed {
    logic [1:0] sel;
    logic [7:0] data;
    logic       eop;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk  = 0;
  int   n_fail = 0;
  bit   sb_en  = 1'b0;
  beat_t exp_q[$];
  logic [31:0] p0;

  vx_commit_rr_arb_if #(.NUM_REQS(4), .DATA_WIDTH(8), .PERF_W(32)) bus ();

  vx_commit_rr_arb #(.NUM_REQS(4), .DATA_WIDTH(8), .PERF_W(32)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #10 clk = ~clk;

  // Beats are checked in the half cycle before the edge that transfers them.
  always @(negedge clk) begin
    beat_t e;
    beat_t got;
    if (sb_en && !rst && bus.out_valid && bus.out_ready) begin
      got   = '{sel: bus.out_sel, data: bus.out_data, eop: bus.out_eop};
      n_chk = n_chk + 1;
      if (exp_q.size() == 0) begin
        n_fail = n_fail + 1;
        $display("FAIL sb_unexpected: got sel=%0d data=%h eop=%b, expected no beat", got.sel, got.data, got.eop);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          n_fail = n_fail + 1;
          $display("FAIL sb_beat: got sel=%0d data=%h eop=%b, expected sel=%0d data=%h eop=%b",
                   got.sel, got.data, got.eop, e.sel, e.data, e.eop);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ready(input logic [3:0] exp, input string name);
    @(negedge clk);
    n_chk = n_chk + 1;
    if (bus.req_ready !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: req_ready=%b, expected %b", name, bus.req_ready, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [7:0] d, input logic eop);
    bus.req_data[i*8 +: 8] = d;
    bus.req_eop[i]         = eop;
  endtask

  task automatic test_reset();
    bus.req_valid = 4'hF;
    bus.req_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    bus.req_eop   = 4'hF;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    #3;
    n_chk = n_chk + 1;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00 || bus.out_eop !== 1'b0 ||
        bus.out_sel !== 2'd0 || bus.perf_stalls !== 32'd0) begin
      n_fail = n_fail + 1;
      $display("FAIL reset_outputs: valid=%b data=%h eop=%b sel=%0d perf=%0d, expected all zero",
               bus.out_valid, bus.out_data, bus.out_eop, bus.out_sel, bus.perf_stalls);
    end
    n_chk = n_chk + 1;
    if (bus.req_ready !== 4'b0000) begin
      n_fail = n_fail + 1;
      $display("FAIL reset_ready: req_ready=%b, expected 0000", bus.req_ready);
    end
    bus.req_valid = 4'h0;
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_rr_all();
    p0 = bus.perf_stalls;
    for (int k = 0; k < 8; k++) exp_q.push_back('{sel: 2'(k % 4), data: 8'(8'hA0 + k % 4), eop: 1'b1});
    bus.req_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    bus.req_eop   = 4'hF;
    bus.req_valid = 4'hF;
    for (int k = 0; k < 8; k++) begin
      chk_ready(4'(1 << (k % 4)), "rr_grant");
      tick();
      n_chk = n_chk + 1;
      if (bus.out_valid !== 1'b1 || bus.out_sel !== 2'(k % 4)) begin
        n_fail = n_fail + 1;
        $display("FAIL rr_out: cycle %0d valid=%b sel=%0d, expected valid=1 sel=%0d",
                 k + 1, bus.out_valid, bus.out_sel, k % 4);
      end
    end
    bus.req_valid = 4'h0;
    n_chk = n_chk + 1;
    if (bus.perf_stalls !== p0) begin
      n_fail = n_fail + 1;
      $display("FAIL rr_no_stall: perf_stalls=%0d, expected %0d", bus.perf_stalls, p0);
    end
    tick();
  endtask

  task automatic test_packet_lock();
    exp_q.push_back('{sel: 2'd1, data: 8'h11, eop: 1'b0});
    exp_q.push_back('{sel: 2'd1, data: 8'h12, eop: 1'b0});
    exp_q.push_back('{sel: 2'd1, data: 8'h13, eop: 1'b1});
    exp_q.push_back('{sel: 2'd2, data: 8'hA2, eop: 1'b1});
    exp_q.push_back('{sel: 2'd0, data: 8'hA0, eop: 1'b1});
    set_req(1, 8'h11, 1'b0);
    bus.req_valid = 4'b0010;
    chk_ready(4'b0010, "pkt_first");
    tick();
    set_req(1, 8'h12, 1'b0);
    bus.req_valid = 4'b0111;
    chk_ready(4'b0010, "pkt_locked_mid");
    tick();
    set_req(1, 8'h13, 1'b1);
    chk_ready(4'b0010, "pkt_locked_eop");
    tick();
    n_chk = n_chk + 1;
    if (bus.out_data !== 8'h13 || bus.out_sel !== 2'd1 || bus.out_eop !== 1'b1) begin
      n_fail = n_fail + 1;
      $display("FAIL pkt_last: data=%h sel=%0d eop=%b, expected 13/1/1", bus.out_data, bus.out_sel, bus.out_eop);
    end
    bus.req_valid = 4'b0101;
    chk_ready(4'b0100, "pkt_after_unlock");
    tick();
    bus.req_valid = 4'b0001;
    chk_ready(4'b0001, "pkt_then_req0");
    tick();
    bus.req_valid = 4'b0000;
    tick();
  endtask

  task automatic test_backpressure();
    p0 = bus.perf_stalls;
    exp_q.push_back('{sel: 2'd2, data: 8'hB0, eop: 1'b1});
    exp_q.push_back('{sel: 2'd2, data: 8'hB1, eop: 1'b1});
    bus.out_ready = 1'b0;
    bus.req_eop   = 4'hF;
    set_req(2, 8'hB0, 1'b1);
    bus.req_valid = 4'b0100;
    chk_ready(4'b0100, "bp_first_load");
    tick();
    set_req(2, 8'hB1, 1'b1);
    for (int k = 0; k < 4; k++) begin
      chk_ready(4'b0000, "bp_ready_low");
      tick();
      n_chk = n_chk + 1;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hB0) begin
        n_fail = n_fail + 1;
        $display("FAIL bp_hold: valid=%b data=%h, expected 1/b0", bus.out_valid, bus.out_data);
      end
    end
    n_chk = n_chk + 1;
    if (bus.perf_stalls !== p0 + 32'd4) begin
      n_fail = n_fail + 1;
      $display("FAIL bp_stalls: perf_stalls=%0d, expected %0d", bus.perf_stalls, p0 + 32'd4);
    end
    bus.out_ready = 1'b1;
    chk_ready(4'b0100, "bp_load_while_drain");
    tick();
    n_chk = n_chk + 1;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hB1) begin
      n_fail = n_fail + 1;
      $display("FAIL bp_no_bubble: valid=%b data=%h, expected 1/b1", bus.out_valid, bus.out_data);
    end
    bus.req_valid = 4'b0000;
    tick();
  endtask

  task automatic test_lock_hole();
    p0 = bus.perf_stalls;
    exp_q.push_back('{sel: 2'd3, data: 8'hC0, eop: 1'b0});
    exp_q.push_back('{sel: 2'd3, data: 8'hC1, eop: 1'b1});
    exp_q.push_back('{sel: 2'd0, data: 8'hA0, eop: 1'b1});
    set_req(3, 8'hC0, 1'b0);
    bus.req_valid = 4'b1000;
    chk_ready(4'b1000, "hole_start");
    tick();
    set_req(0, 8'hA0, 1'b1);
    bus.req_valid = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      chk_ready(4'b0000, "hole_no_grant");
      tick();
      n_chk = n_chk + 1;
      if (bus.out_valid !== 1'b0) begin
        n_fail = n_fail + 1;
        $display("FAIL hole_out_valid: out_valid=%b, expected 0", bus.out_valid);
      end
    end
    n_chk = n_chk + 1;
    if (bus.perf_stalls !== p0 + 32'd3) begin
      n_fail = n_fail + 1;
      $display("FAIL hole_stalls: perf_stalls=%0d, expected %0d", bus.perf_stalls, p0 + 32'd3);
    end
    set_req(3, 8'hC1, 1'b1);
    bus.req_valid = 4'b1001;
    chk_ready(4'b1000, "hole_resume");
    tick();
    bus.req_valid = 4'b0001;
    chk_ready(4'b0001, "hole_req0_after");
    tick();
    bus.req_valid = 4'b0000;
    tick();
  endtask

  task automatic test_async_reset();
    sb_en = 1'b0;
    set_req(1, 8'h11, 1'b0);
    bus.req_valid = 4'b0010;
    tick();
    set_req(1, 8'h12, 1'b0);
    set_req(0, 8'hA0, 1'b1);
    bus.req_valid = 4'b0011;
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_chk = n_chk + 1;
    if (bus.out_valid !== 1'b0 || bus.req_ready !== 4'b0000) begin
      n_fail = n_fail + 1;
      $display("FAIL arst_immediate: out_valid=%b req_ready=%b, expected 0/0000", bus.out_valid, bus.req_ready);
    end
    #2;
    rst = 1'b0;
    set_req(1, 8'h11, 1'b0);
    #1;
    n_chk = n_chk + 1;
    if (bus.req_ready !== 4'b0001) begin
      n_fail = n_fail + 1;
      $display("FAIL arst_first_winner: req_ready=%b, expected 0001", bus.req_ready);
    end
    exp_q.push_back('{sel: 2'd0, data: 8'hA0, eop: 1'b1});
    exp_q.push_back('{sel: 2'd1, data: 8'h11, eop: 1'b0});
    exp_q.push_back('{sel: 2'd1, data: 8'h12, eop: 1'b0});
    exp_q.push_back('{sel: 2'd1, data: 8'h13, eop: 1'b1});
    sb_en = 1'b1;
    tick();
    bus.req_valid = 4'b0010;
    chk_ready(4'b0010, "arst_restart");
    tick();
    set_req(1, 8'h12, 1'b0);
    tick();
    set_req(1, 8'h13, 1'b1);
    tick();
    bus.req_valid = 4'b0000;
    tick();
  endtask

  task automatic test_saturation();
    exp_q.push_back('{sel: 2'd0, data: 8'hA0, eop: 1'b1});
    bus.out_ready = 1'b0;
    set_req(0, 8'hA0, 1'b1);
    bus.req_valid = 4'b0001;
    tick();
    force dut.perf_q = 32'hFFFF_FFFE;
    #1;
    release dut.perf_q;
    tick();
    n_chk = n_chk + 1;
    if (bus.perf_stalls !== 32'hFFFF_FFFF) begin
      n_fail = n_fail + 1;
      $display("FAIL sat_reach: perf_stalls=%h, expected ffffffff", bus.perf_stalls);
    end
    tick();
    tick();
    n_chk = n_chk + 1;
    if (bus.perf_stalls !== 32'hFFFF_FFFF) begin
      n_fail = n_fail + 1;
      $display("FAIL sat_hold: perf_stalls=%h, expected ffffffff", bus.perf_stalls);
    end
    bus.req_valid = 4'b0000;
    bus.out_ready = 1'b1;
    tick();
    tick();
  endtask

  initial begin
    bus.req_valid = 4'h0;
    bus.req_data  = '0;
    bus.req_eop   = 4'h0;
    bus.out_ready = 1'b1;
    test_reset();
    sb_en = 1'b1;
    test_rr_all();
    test_packet_lock();
    test_backpressure();
    test_lock_hole();
    test_async_reset();
    test_saturation();
    n_chk = n_chk + 1;
    if (exp_q.size() != 0) begin
      n_fail = n_fail + 1;
      $display("FAIL sb_leftover: %0d expected beats never seen, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
